// File: rtl/cpu_run_ctrl.sv
// Run/pause/step/halt sequencer that gates a CPU clock enable and
// snoops CPU stores for a display byte and a halt request.
module cpu_run_ctrl #(
   parameter int unsigned DIV_W     = 19,
   parameter logic [31:0] OUT_ADDR  = 32'h00000014,
   parameter logic [31:0] HALT_ADDR = 32'h00000018
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        btn_run,
   input  logic        btn_step,
   input  logic        mem_write_i,
   input  logic [31:0] data_adr_i,
   input  logic [31:0] write_data_i,
   output logic        cpu_clk_en_o,
   output logic        cpu_reset_o,
   output logic [1:0]  state_o,
   output logic [7:0]  out_byte_o,
   output logic        out_valid_o,
   output logic        halted_o,
   output logic [15:0] cycle_cnt_o
);

   localparam logic [1:0] S_RST   = 2'd0;
   localparam logic [1:0] S_PAUSE = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_HALT  = 2'd3;

   logic [1:0]       r_state;
   logic [1:0]       r_hold;
   logic [DIV_W-1:0] r_tick;
   logic             r_run_q;
   logic             r_step_q;
   logic             r_step_pend;
   logic [7:0]       r_out_byte;
   logic             r_out_valid;
   logic [15:0]      r_cyc_cnt;

   logic       w_run_edge;
   logic       w_step_edge;
   logic       w_clk_en;
   logic       w_commit;
   logic       w_out_hit;
   logic       w_halt_hit;
   logic [1:0] w_state_nxt;
   logic       w_unused;

   assign w_run_edge  = btn_run & ~r_run_q;
   assign w_step_edge = btn_step & ~r_step_q;
   assign w_commit    = mem_write_i & w_clk_en;
   assign w_out_hit   = w_commit & (data_adr_i == OUT_ADDR);
   assign w_halt_hit  = w_commit & (data_adr_i == HALT_ADDR);
   assign w_unused    = ^write_data_i[31:8];

   // Reset-hold pulses land on r==1 and r==3, i.e. odd counts.
   always_comb begin
      w_clk_en = 1'b0;
      unique case (r_state)
         S_RST:   w_clk_en = r_hold[0];
         S_PAUSE: w_clk_en = r_step_pend;
         S_RUN:   w_clk_en = &r_tick;
         default: w_clk_en = 1'b0;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_RST: begin
            if (r_hold == 2'd3)
               w_state_nxt = S_PAUSE;
         end
         S_PAUSE, S_RUN: begin
            if (w_halt_hit)
               w_state_nxt = S_HALT;
            else if (w_run_edge)
               w_state_nxt = (r_state == S_RUN) ? S_PAUSE : S_RUN;
         end
         default: begin
            if (w_run_edge)
               w_state_nxt = S_RST;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_RST;
         r_hold      <= 2'd0;
         r_tick      <= '0;
         r_run_q     <= 1'b0;
         r_step_q    <= 1'b0;
         r_step_pend <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_run_q     <= btn_run;
         r_step_q    <= btn_step;
         r_hold      <= (r_state == S_RST) ? r_hold + 2'd1 : 2'd0;
         r_step_pend <= (r_state == S_PAUSE) && (w_state_nxt == S_PAUSE)
                        && w_step_edge;
         if ((r_state == S_RUN) && (w_state_nxt == S_RUN))
            r_tick <= r_tick + 1'b1;
         else
            r_tick <= '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_out_byte  <= 8'd0;
         r_out_valid <= 1'b0;
         r_cyc_cnt   <= 16'd0;
      end else begin
         r_out_valid <= w_out_hit;
         if (w_out_hit)
            r_out_byte <= write_data_i[7:0];
         if ((w_state_nxt == S_RST) && (r_state != S_RST))
            r_cyc_cnt <= 16'd0;
         else if (w_clk_en && (r_state != S_RST) && (r_cyc_cnt != 16'hFFFF))
            r_cyc_cnt <= r_cyc_cnt + 16'd1;
      end
   end

   assign cpu_clk_en_o = w_clk_en;
   assign cpu_reset_o  = (r_state == S_RST);
   assign state_o      = r_state;
   assign out_byte_o   = r_out_byte;
   assign out_valid_o  = r_out_valid;
   assign halted_o     = (r_state == S_HALT);
   assign cycle_cnt_o  = r_cyc_cnt;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: stimulus queues expected pulses
// and display strobes; a negedge monitor pops and compares them.
module tb_cpu_run_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        btn_run;
   logic        btn_step;
   logic        mem_write_i;
   logic [31:0] data_adr_i;
   logic [31:0] write_data_i;
   logic        cpu_clk_en_o;
   logic        cpu_reset_o;
   logic [1:0]  state_o;
   logic [7:0]  out_byte_o;
   logic        out_valid_o;
   logic        halted_o;
   logic [15:0] cycle_cnt_o;

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;
   int q_pulse[$];
   int q_out_cyc[$];
   logic [7:0] q_out_byte[$];

   cpu_run_ctrl #(.DIV_W(4)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .btn_run      (btn_run),
      .btn_step     (btn_step),
      .mem_write_i  (mem_write_i),
      .data_adr_i   (data_adr_i),
      .write_data_i (write_data_i),
      .cpu_clk_en_o (cpu_clk_en_o),
      .cpu_reset_o  (cpu_reset_o),
      .state_o      (state_o),
      .out_byte_o   (out_byte_o),
      .out_valid_o  (out_valid_o),
      .halted_o     (halted_o),
      .cycle_cnt_o  (cycle_cnt_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tick_to(input int c);
      if (c > cyc)
         tick(c - cyc);
   endtask

   // Monitor: every clock-enable pulse and display strobe must be expected.
   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         if (cpu_clk_en_o) begin
            if (q_pulse.size() == 0)
               chk("unexpected_pulse", cyc, 32'hFFFF_FFFF);
            else
               chk("pulse_cycle", cyc, q_pulse.pop_front());
         end
         if (out_valid_o) begin
            if (q_out_cyc.size() == 0)
               chk("unexpected_out_valid", cyc, 32'hFFFF_FFFF);
            else begin
               chk("out_valid_cycle", cyc, q_out_cyc.pop_front());
               chk("out_byte", {24'd0, out_byte_o}, {24'd0, q_out_byte.pop_front()});
            end
         end
      end
   end

   int c0, e, h;

   initial begin
      reset_n      = 1'b0;
      btn_run      = 1'b0;
      btn_step     = 1'b0;
      mem_write_i  = 1'b0;
      data_adr_i   = 32'd0;
      write_data_i = 32'd0;
      tick(3);
      chk("rst_state", state_o, 0);
      chk("rst_cpu_reset", cpu_reset_o, 1);
      chk("rst_clk_en", cpu_clk_en_o, 0);
      chk("rst_out_byte", out_byte_o, 0);
      chk("rst_out_valid", out_valid_o, 0);
      chk("rst_halted", halted_o, 0);
      chk("rst_cycle_cnt", cycle_cnt_o, 0);

      // Power-up sequencing.
      reset_n = 1'b1;
      c0 = cyc;
      q_pulse.push_back(c0 + 1);
      q_pulse.push_back(c0 + 3);
      chk("hold_cpu_reset", cpu_reset_o, 1);
      tick(3);
      chk("hold_cpu_reset_c3", cpu_reset_o, 1);
      tick(1);
      chk("hold_to_pause", state_o, 1);
      chk("pause_cpu_reset", cpu_reset_o, 0);
      chk("hold_cycle_cnt", cycle_cnt_o, 0);

      // Step held for ten cycles gives a single pulse.
      btn_step = 1'b1;
      q_pulse.push_back(cyc + 1);
      tick(10);
      btn_step = 1'b0;
      chk("step_cycle_cnt", cycle_cnt_o, 1);
      tick(2);

      // Free run, then pause.
      btn_run = 1'b1;
      e = cyc + 1;
      tick(1);
      btn_run = 1'b0;
      chk("run_state", state_o, 2);
      q_pulse.push_back(e + 15);
      q_pulse.push_back(e + 31);
      q_pulse.push_back(e + 47);
      tick_to(e + 49);
      btn_run = 1'b1;
      tick(1);
      btn_run = 1'b0;
      chk("pause_state", state_o, 1);
      tick(30);
      chk("run_cycle_cnt", cycle_cnt_o, 4);

      // Display write committed only on a pulse.
      btn_run = 1'b1;
      e = cyc + 1;
      tick(1);
      btn_run = 1'b0;
      mem_write_i  = 1'b1;
      data_adr_i   = 32'h14;
      write_data_i = 32'hA5;
      q_pulse.push_back(e + 15);
      q_out_cyc.push_back(e + 16);
      q_out_byte.push_back(8'hA5);
      tick_to(e + 16);
      write_data_i = 32'h5A;
      tick(10);
      mem_write_i = 1'b0;
      chk("out_no_update", out_byte_o, 8'hA5);

      // Halt commit and run edge together: halt wins.
      tick_to(e + 31);
      q_pulse.push_back(e + 31);
      btn_run     = 1'b1;
      mem_write_i = 1'b1;
      data_adr_i  = 32'h18;
      tick(1);
      btn_run     = 1'b0;
      mem_write_i = 1'b0;
      chk("halt_state", state_o, 3);
      chk("halt_flag", halted_o, 1);
      chk("halt_cycle_cnt", cycle_cnt_o, 6);
      tick(64);
      btn_step = 1'b1;
      tick(2);
      btn_step = 1'b0;
      tick(4);
      chk("halt_step_ignored", state_o, 3);

      // Restart from halt.
      btn_run = 1'b1;
      h = cyc + 1;
      tick(1);
      btn_run = 1'b0;
      q_pulse.push_back(h + 1);
      q_pulse.push_back(h + 3);
      chk("restart_state", state_o, 0);
      chk("restart_cpu_reset", cpu_reset_o, 1);
      chk("restart_halted", halted_o, 0);
      chk("restart_cycle_cnt", cycle_cnt_o, 0);
      chk("restart_out_byte", out_byte_o, 8'hA5);
      tick(4);
      chk("restart_pause", state_o, 1);

      // Near-miss addresses are ignored.
      mem_write_i  = 1'b1;
      data_adr_i   = 32'h0000_0114;
      write_data_i = 32'h77;
      btn_step     = 1'b1;
      q_pulse.push_back(cyc + 1);
      tick(2);
      btn_step   = 1'b0;
      tick(2);
      data_adr_i = 32'h8000_0018;
      btn_step   = 1'b1;
      q_pulse.push_back(cyc + 1);
      tick(2);
      btn_step    = 1'b0;
      mem_write_i = 1'b0;
      tick(2);
      chk("addr_no_halt", state_o, 1);
      chk("addr_no_out", out_byte_o, 8'hA5);
      chk("addr_cycle_cnt", cycle_cnt_o, 2);

      // Step and run together: run only, no step pulse.
      btn_run  = 1'b1;
      btn_step = 1'b1;
      e = cyc + 1;
      tick(1);
      btn_run  = 1'b0;
      btn_step = 1'b0;
      chk("both_run_state", state_o, 2);
      tick_to(e + 15);
      chk("mid_pulse_en", cpu_clk_en_o, 1);

      // Reset in the middle of a run pulse.
      reset_n = 1'b0;
      #1;
      chk("async_clk_en", cpu_clk_en_o, 0);
      chk("async_cpu_reset", cpu_reset_o, 1);
      chk("async_state", state_o, 0);
      chk("async_out_byte", out_byte_o, 0);
      chk("async_out_valid", out_valid_o, 0);
      chk("async_halted", halted_o, 0);
      chk("async_cycle_cnt", cycle_cnt_o, 0);
      tick(2);
      reset_n = 1'b1;
      c0 = cyc;
      q_pulse.push_back(c0 + 1);
      q_pulse.push_back(c0 + 3);
      tick(5);
      chk("rerelease_pause", state_o, 1);

      chk("pulse_queue_drained", q_pulse.size(), 0);
      chk("out_queue_drained", q_out_cyc.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
